// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter.
// Write strobes are edge-detected; frames go out back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data_in,
  input  logic               we,
  output logic               busy,
  output logic               tx,
  output logic               tx_active,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [15:0] BAUD_TOP =
    16'(CLKS_PER_BIT - 1);

  localparam logic [FIFO_AW:0] FULL =
    (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [15:0]        baud_q;
  logic [15:0]        baud_d;

  logic [2:0]         bit_q;
  logic [2:0]         bit_d;

  logic [7:0]         sh_q;
  logic [7:0]         sh_d;

  logic               we_q;
  logic               wr_req;
  logic               accept;
  logic               pop;
  logic               have;
  logic               baud_end;

  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   cnt;

  logic [7:0]         mem [DEPTH];

  assign have       = (cnt != '0);
  assign busy       = (cnt == FULL);
  assign fifo_count = cnt;
  assign tx_active  = (state_q != IDLE);
  assign baud_end   = (baud_q == '0);

  // One request per rising edge of the strobe.
  assign wr_req = we & ~we_q;

  // A full FIFO still takes a write when a pop frees a slot.
  assign accept = wr_req & (~busy | pop);

  // Strobe history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
    end else begin
      we_q <= we;
    end
  end

  // FIFO storage, written at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[wptr] <= data_in;
    end
  end

  // Head/tail pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !accept) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Sticky flag for dropped writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_req && !accept) begin
      overflow <= 1'b1;
    end
  end

  // Transmitter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state, bit timing and FIFO pop decision.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (have) begin
          pop     = 1'b1;
          sh_d    = mem[rptr];
          baud_d  = BAUD_TOP;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = BAUD_TOP;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = BAUD_TOP;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = BAUD_TOP;
          if (have) begin
            pop     = 1'b1;
            sh_d    = mem[rptr];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
    endcase
  end

  // Line driver is a flop so tx never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= 1'b1;
    end else if (state_q == START) begin
      tx <= 1'b0;
    end else if (state_q == DATA) begin
      tx <= sh_q[0];
    end else begin
      tx <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the FIFO-fed 8N1 sender.
// Line samples are logged each cycle and compared to ideal frames.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       we;
  logic       sel;

  logic       we4;
  logic       we2;

  logic       busy4, tx4, act4, ovf4;
  logic [2:0] cnt4;
  logic       busy2, tx2, act2, ovf2;
  logic [2:0] cnt2;

  logic       tx_m;
  logic       act_m;
  logic       busy_m;
  logic       ovf_m;
  logic [2:0] cnt_m;

  int errors;
  int checks;

  logic       txq [$];
  logic       actq [$];
  logic [7:0] bq [$];

  assign we4    = we & ~sel;
  assign we2    = we & sel;
  assign tx_m   = sel ? tx2 : tx4;
  assign act_m  = sel ? act2 : act4;
  assign busy_m = sel ? busy2 : busy4;
  assign ovf_m  = sel ? ovf2 : ovf4;
  assign cnt_m  = sel ? cnt2 : cnt4;

  uart_tx_fifo #(
    .CLKS_PER_BIT(4),
    .FIFO_AW(2)
  ) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data),
    .we(we4),
    .busy(busy4),
    .tx(tx4),
    .tx_active(act4),
    .overflow(ovf4),
    .fifo_count(cnt4)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(2),
    .FIFO_AW(2)
  ) dut2 (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data),
    .we(we2),
    .busy(busy2),
    .tx(tx2),
    .tx_active(act2),
    .overflow(ovf2),
    .fifo_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    txq.push_back(tx_m);
    actq.push_back(act_m);
  endtask

  task automatic clr();
    txq.delete();
    actq.delete();
    bq.delete();
  endtask

  task automatic wr(input logic [7:0] d);
    data = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
    step();
  endtask

  // Line must idle for two samples, then carry bq frames back-to-back.
  task automatic line_check(input string tag, input int cpb);
    int bad;
    int fl;
    int n;
    bad = 0;
    fl  = 10 * cpb;
    n   = bq.size();
    for (int i = 0; i < txq.size(); i++) begin
      int         pos;
      int         f;
      int         b;
      logic [7:0] by;
      logic       e;
      pos = i - 2;
      if (pos < 0 || pos >= fl * n) begin
        e = 1'b1;
      end else begin
        f  = pos / fl;
        b  = (pos % fl) / cpb;
        by = bq[f];
        if (b == 0) e = 1'b0;
        else if (b == 9) e = 1'b1;
        else e = by[b-1];
      end
      if (txq[i] !== e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  function automatic int act_ones();
    int n;
    n = 0;
    foreach (actq[i]) if (actq[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int tx_zeros();
    int n;
    n = 0;
    foreach (txq[i]) if (txq[i] !== 1'b1) n++;
    return n;
  endfunction

  initial begin
    int mx;
    errors = 0;
    checks = 0;
    sel    = 1'b0;
    we     = 1'b0;
    data   = 8'h00;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_active", act4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_tx2", tx2, 1);
    rst_n = 1'b1;
    step();
    step();

    // single byte, one-cycle strobe
    clr();
    bq.push_back(8'hA5);
    data = 8'hA5;
    we   = 1'b1;
    step();
    we   = 1'b0;
    chk("t1_cnt_wr", cnt_m, 1);
    step();
    chk("t1_cnt_pop", cnt_m, 0);
    chk("t1_active", act_m, 1);
    chk("t1_tx_lag", tx_m, 1);
    repeat (45) step();
    line_check("t1_line", 4);
    chk("t1_act_len", act_ones(), 40);
    chk("t1_cnt_end", cnt_m, 0);
    chk("t1_idle", act_m, 0);

    // strobe held three cycles gives one frame
    clr();
    bq.push_back(8'h3C);
    data = 8'h3C;
    we   = 1'b1;
    step();
    chk("t2_cnt_wr", cnt_m, 1);
    step();
    chk("t2_cnt_pop", cnt_m, 0);
    step();
    we = 1'b0;
    mx = 0;
    repeat (60) begin
      step();
      if (int'(cnt_m) > mx) mx = int'(cnt_m);
    end
    chk("t2_cnt_max", mx, 0);
    chk("t2_ovf", ovf_m, 0);
    line_check("t2_line", 4);
    chk("t2_act_len", act_ones(), 40);

    // fill, overflow, back-to-back drain
    clr();
    for (int i = 1; i <= 5; i++) bq.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr(8'(i));
    chk("t3_busy_full", busy_m, 1);
    chk("t3_cnt_full", cnt_m, 4);
    chk("t3_ovf", ovf_m, 1);
    repeat (29) step();
    chk("t3_busy_pre", busy_m, 1);
    step();
    chk("t3_busy_pop", busy_m, 0);
    chk("t3_cnt_pop", cnt_m, 3);
    repeat (170) step();
    line_check("t3_line", 4);
    chk("t3_act_len", act_ones(), 200);
    chk("t3_ovf_sticky", ovf_m, 1);

    // write lands on the pop edge of a full FIFO
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t4_ovf_clr", ovf_m, 0);
    clr();
    for (int i = 0; i < 6; i++) bq.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i));
    repeat (31) step();
    chk("t4_cnt_pre", cnt_m, 4);
    chk("t4_busy_pre", busy_m, 1);
    data = 8'h16;
    we   = 1'b1;
    step();
    we   = 1'b0;
    chk("t4_cnt_same", cnt_m, 4);
    chk("t4_ovf", ovf_m, 0);
    repeat (215) step();
    line_check("t4_line", 4);
    chk("t4_cnt_end", cnt_m, 0);

    // asynchronous reset mid-frame
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clr();
    for (int i = 0; i < 3; i++) wr(8'h00);
    chk("t5_cnt_q", cnt_m, 2);
    repeat (8) step();
    chk("t5_tx_mid", tx_m, 0);
    chk("t5_act_mid", act_m, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_tx_async", tx_m, 1);
    chk("t5_act_async", act_m, 0);
    chk("t5_cnt_async", cnt_m, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    repeat (60) step();
    chk("t5_quiet_tx", tx_zeros(), 0);
    chk("t5_quiet_act", act_ones(), 0);
    clr();
    bq.push_back(8'h5A);
    wr(8'h5A);
    repeat (44) step();
    line_check("t5_after", 4);

    // fast baud, two frames back-to-back
    sel = 1'b1;
    clr();
    bq.push_back(8'hFF);
    bq.push_back(8'h00);
    wr(8'hFF);
    wr(8'h00);
    repeat (43) step();
    line_check("t6_line", 2);
    chk("t6_act_len", act_ones(), 40);
    chk("t6_ovf", ovf_m, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial-transmit end of the memory-mapped serial port.
- Accepts bytes from the IO register block's serial-out data/write-strobe pair and queues them in a small FIFO.
- Serialises each byte as 8N1 on the tx line and reports back-pressure through busy, which software polls before writing.
- Sits between the IO register block and the board UART pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 2..65535.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
data_in  input  8  byte to transmit; held stable by the IO block while we is high.
we  input  1  write strobe; may stay high for more than one cycle per write.
busy  output  1  high when the FIFO is full (count == 2**FIFO_AW).
tx  output  1  serial line; idle high.
tx_active  output  1  high while a frame is on the line (FSM not IDLE).
overflow  output  1  sticky; set when a write is dropped because the FIFO is full.
fifo_count  output  FIFO_AW+1  number of queued bytes, excluding the byte currently shifting.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, busy=0, tx_active=0, overflow=0, fifo_count=0.
  - FSM=IDLE; read and write pointers=0; we_q=0.
  - Reset mid-frame aborts the frame immediately and drives tx high in the same instant. Queued bytes are discarded.
- Write detection:
  - we_q registers we each cycle.
  - An enqueue request is we & ~we_q (rising edge only). A strobe held N cycles enqueues exactly one byte.
  - data_in is sampled on the same edge as the request.
- Enqueue/pop rules:
  - The request is accepted if fifo_count < depth, or if a pop occurs on the same edge. Write and pop on the same edge leave fifo_count unchanged.
  - A request that is not accepted is dropped, and overflow is set to 1. overflow clears only on reset.
  - Pointers wrap modulo depth. fifo_count is computed as +1/-1/0 with no wrap.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count > 0 on an edge, pop the head into shift register sh[7:0], load baud_cnt = CLKS_PER_BIT-1, bit_idx = 0, and go to START.
  - A byte written into an empty FIFO while IDLE is popped on the next edge. tx falls on the 2nd rising edge after the one where we is first sampled high.
  - START: tx=0.
  - DATA: tx = sh[0].
  - STOP: tx=1.
  - Timing within START, DATA and STOP: baud_cnt decrements each cycle. When baud_cnt == 0:
    - START → DATA.
    - DATA: shift sh right. When bit_idx == 7 go to STOP; otherwise increment bit_idx.
    - Reload baud_cnt = CLKS_PER_BIT-1 on every transition.
  - STOP end (baud_cnt == 0): if fifo_count > 0, pop and go directly to START, so there are no idle cycles between frames. Otherwise go to IDLE.
- Frame shape:
  - Every state holds exactly CLKS_PER_BIT cycles. A frame is exactly 10*CLKS_PER_BIT cycles.
  - Data is sent LSB first.
  - tx is driven from a register, so it carries no combinational glitches.
- busy and fifo_count reflect register state after each edge.
- tx_active = (state != IDLE).

Test Plan:
1. CLKS_PER_BIT=4, write 0xA5 (single-cycle we) -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles. 40 cycles total; tx_active high for exactly those 40 cycles; final fifo_count=0.
2. Write 0x3C with we held high for 3 cycles -> exactly one frame; fifo_count never exceeds 0 after the pop; overflow=0.
3. CLKS_PER_BIT=4, FIFO_AW=2, six writes 0x01..0x06 spaced 2 cycles apart -> 0x01 pops immediately. 0x02..0x05 fill the FIFO, so busy=1 and fifo_count=4. 0x06 is dropped and overflow=1. Line carries 0x01..0x05 with no idle cycles between each stop bit and the next start bit. busy falls at the first pop.
4. FIFO full while a stop bit ends, with a write edge on the same cycle as the pop -> write accepted; fifo_count stays 4; overflow stays 0.
5. Reset asserted 13 cycles into a frame with 2 bytes queued -> tx=1, tx_active=0, fifo_count=0 asynchronously. After release, no frame is transmitted until a new write.
6. CLKS_PER_BIT=2, write 0xFF then 0x00 back-to-back -> frames of 20 cycles each. Stop bit to start bit of the second frame is one 2-cycle high period only.
